ahb2apb_bridge: RTL and testbench

- AHB-Lite slave that converts single AHB transfers into APB3 transfers for the low-speed peripheral region.
- Occupies a spare slave slot of the system AHB slave multiplexer: it receives the decoder HSEL and the bus HREADY, and returns HREADYOUT/HRESP/HRDATA to the mux.
- Downstream, it drives one APB3 segment with a single PSEL, because APB decoding is external.
- Adds a PREADY timeout so that a hung peripheral cannot stall the system bus.

---
 rtl/ahb2apb_bridge.sv | 160 ++++++++++++++++
 tb/tb_ahb2apb_bridge.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave that turns each accepted AHB transfer into one
// 32-bit APB3 access on a single downstream segment. A PREADY timeout converts a
// hung peripheral into the AHB two-cycle ERROR response instead of a bus stall.
//
// Handshakes:
//   AHB: an address phase is taken when HSEL & HREADY & HTRANS[1] while the
//        bridge sits in IDLE or ERR2. The data phase ends on the cycle
//        HREADYOUT=1; HRESP=1 on ERR1 (HREADYOUT=0) and ERR2 (HREADYOUT=1)
//        forms the two-cycle error.
//   APB: PSEL rises for SETUP (PENABLE=0) and stays high through ACCESS
//        (PENABLE=1). The access completes on the cycle PSEL & PENABLE &
//        PREADY, where PSLVERR is also sampled.
module ahb2apb_bridge #(
   parameter int ADDR_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic                  HREADY,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [31:0]           HWDATA,
   output logic                  HREADYOUT,
   output logic                  HRESP,
   output logic [31:0]           HRDATA,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [31:0]           PWDATA,
   input  logic [31:0]           PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR,
   output logic [2:0]            o_dbg_state
);

   // Counter only has to reach TIMEOUT-1, so it is sized for that value.
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WDATA  = 3'd1,
      S_SETUP  = 3'd2,
      S_ACCESS = 3'd3,
      S_ERR1   = 3'd4,
      S_ERR2   = 3'd5
   } state_t;

   state_t                r_state;
   logic                  r_hreadyout;
   logic                  r_hresp;
   logic [31:0]           r_hrdata;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [31:0]           r_pwdata;
   logic [CNT_W-1:0]      r_cnt;

   logic w_accept;
   logic w_timeout;
   logic w_unused;

   // HTRANS[0] only separates NONSEQ from SEQ, and every transfer is handled alike.
   assign w_unused  = HTRANS[0];
   assign w_accept  = HSEL & HREADY & HTRANS[1] & ((r_state == S_IDLE) | (r_state == S_ERR2));
   assign w_timeout = (TIMEOUT != 0) && !PREADY && (r_cnt == TO_LAST);

   // Bridge FSM; every bus-facing output is a register updated here.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_state     <= S_IDLE;
         r_hreadyout <= 1'b1;
         r_hresp     <= 1'b0;
         r_hrdata    <= '0;
         r_paddr     <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_ERR2: begin
               // ERR2 is the second error cycle; HRESP clears after it.
               r_hresp     <= 1'b0;
               r_hreadyout <= 1'b1;
               r_state     <= S_IDLE;
               if (w_accept) begin
                  r_paddr     <= HADDR;
                  r_pwrite    <= HWRITE;
                  r_hreadyout <= 1'b0;
                  if (HWRITE) begin
                     r_state <= S_WDATA;
                  end else begin
                     r_psel  <= 1'b1;
                     r_state <= S_SETUP;
                  end
               end
            end
            S_WDATA: begin
               // HWDATA is valid only in the AHB data phase, one cycle after the address.
               r_pwdata <= HWDATA;
               r_psel   <= 1'b1;
               r_state  <= S_SETUP;
            end
            S_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (PREADY) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_cnt     <= '0;
                  if (PSLVERR) begin
                     r_hresp <= 1'b1;
                     r_state <= S_ERR1;
                  end else begin
                     if (!r_pwrite) begin
                        r_hrdata <= PRDATA;
                     end
                     r_hreadyout <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end else if (w_timeout) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_cnt     <= '0;
                  r_hresp   <= 1'b1;
                  r_state   <= S_ERR1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_ERR1: begin
               r_hreadyout <= 1'b1;
               r_state     <= S_ERR2;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign HREADYOUT   = r_hreadyout;
   assign HRESP       = r_hresp;
   assign HRDATA      = r_hrdata;
   assign PADDR       = r_paddr;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PWDATA      = r_pwdata;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed scenarios for the AHB-to-APB bridge, built with a
// short timeout (4 ACCESS cycles) so the timeout path is reachable quickly.
module tb_ahb2apb_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic        HREADY;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [15:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  ahb2apb_bridge #(.ADDR_WIDTH(16), .TIMEOUT(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HADDR(HADDR), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge HCLK);
  endtask

  // Address phase in the current cycle, then the data phase (HWDATA) in the next.
  task automatic ahb_addr(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
    HSEL   = 1'b1;
    HREADY = 1'b1;
    HTRANS = 2'b10;
    HWRITE = wr;
    HADDR  = addr;
    tick();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wdata;
  endtask

  // Plays the APB slave: holds PREADY low for 'waits' ACCESS cycles, then high.
  // Returns at the first cycle with HREADYOUT=1 or HRESP=1, counting the cycles
  // before it; -1 if that never happened within the budget.
  task automatic run_apb(input int waits, output int low_cycles);
    int w;
    w = 0;
    low_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      if (HREADYOUT === 1'b1 || HRESP === 1'b1) return;
      low_cycles++;
      if (PENABLE === 1'b1) begin
        if (w < waits) begin
          PREADY = 1'b0;
          w++;
        end else begin
          PREADY = 1'b1;
        end
      end else begin
        PREADY = 1'b0;
      end
      tick();
    end
    low_cycles = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    HRESETn = 1'b0;
    HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HWRITE = 1'b0;
    HADDR = '0; HWDATA = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({HREADYOUT, HRESP, PSEL, PENABLE, PWRITE} !== 5'b10000) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b expected 10000", {HREADYOUT, HRESP, PSEL, PENABLE, PWRITE});
    end
    n_checks++;
    if ({HRDATA, PADDR, PWDATA, dbg_state} !== '0) begin
      n_errors++;
      $display("FAIL reset_data: HRDATA=%h PADDR=%h PWDATA=%h state=%0d expected all 0",
               HRDATA, PADDR, PWDATA, dbg_state);
    end
    HRESETn = 1'b1;
    tick();
  endtask

  task automatic test_write();
    int lc;
    PREADY = 1'b1;
    ahb_addr(1'b1, 16'h0040, 32'hDEADBEEF);
    // WDATA cycle: PSEL not yet up, slave stalling
    n_checks++;
    if ({PSEL, HREADYOUT} !== 2'b00) begin
      n_errors++;
      $display("FAIL write_wdata: PSEL,HREADYOUT=%b expected 00", {PSEL, HREADYOUT});
    end
    tick();
    // SETUP: two cycles after the address phase
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 16'h0040, 32'hDEADBEEF}) begin
      n_errors++;
      $display("FAIL write_setup: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h expected 1 0 1 0040 deadbeef",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick();
    n_checks++;
    if ({PSEL, PENABLE, PADDR, PWDATA, HREADYOUT} !== {1'b1, 1'b1, 16'h0040, 32'hDEADBEEF, 1'b0}) begin
      n_errors++;
      $display("FAIL write_access: PSEL=%b PENABLE=%b PADDR=%h PWDATA=%h HREADYOUT=%b expected 1 1 0040 deadbeef 0",
               PSEL, PENABLE, PADDR, PWDATA, HREADYOUT);
    end
    tick();
    n_checks++;
    if ({HREADYOUT, HRESP, PSEL, PENABLE} !== 4'b1000) begin
      n_errors++;
      $display("FAIL write_done: HREADYOUT,HRESP,PSEL,PENABLE=%b expected 1000", {HREADYOUT, HRESP, PSEL, PENABLE});
    end
    n_checks++;
    if ({PADDR, PWDATA, PWRITE, HRDATA} !== {16'h0040, 32'hDEADBEEF, 1'b1, 32'h0}) begin
      n_errors++;
      $display("FAIL write_hold: PADDR=%h PWDATA=%h PWRITE=%b HRDATA=%h expected 0040 deadbeef 1 00000000",
               PADDR, PWDATA, PWRITE, HRDATA);
    end
    lc = 0;
    PREADY = 1'b0;
    tick();
  endtask

  task automatic test_read_wait();
    int lc;
    PRDATA = 32'h12345678;
    ahb_addr(1'b0, 16'h0044, 32'h0);
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, dbg_state} !== {1'b1, 1'b0, 1'b0, 16'h0044, 3'd2}) begin
      n_errors++;
      $display("FAIL read_setup: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h state=%0d expected 1 0 0 0044 2",
               PSEL, PENABLE, PWRITE, PADDR, dbg_state);
    end
    run_apb(3, lc);
    // SETUP + three waited ACCESS cycles + the completing ACCESS cycle.
    // The last ACCESS cycle also sits on the timeout limit, where PREADY wins.
    n_checks++;
    if (lc !== 5) begin
      n_errors++;
      $display("FAIL read_wait_len: HREADYOUT low for %0d cycles expected 5", lc);
    end
    n_checks++;
    if ({HREADYOUT, HRESP, HRDATA, PSEL} !== {1'b1, 1'b0, 32'h12345678, 1'b0}) begin
      n_errors++;
      $display("FAIL read_wait_data: HREADYOUT=%b HRESP=%b HRDATA=%h PSEL=%b expected 1 0 12345678 0",
               HREADYOUT, HRESP, HRDATA, PSEL);
    end
    PREADY = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    int lc;
    PRDATA  = 32'hCAFEF00D;
    PSLVERR = 1'b1;
    ahb_addr(1'b0, 16'h0048, 32'h0);
    run_apb(0, lc);
    n_checks++;
    if ({lc == 2, HREADYOUT, HRESP, PSEL, PENABLE} !== 5'b10100) begin
      n_errors++;
      $display("FAIL slverr_err1: cycles=%0d HREADYOUT=%b HRESP=%b PSEL=%b PENABLE=%b expected 2 0 1 0 0",
               lc, HREADYOUT, HRESP, PSEL, PENABLE);
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    tick();
    n_checks++;
    if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b1, 32'h12345678}) begin
      n_errors++;
      $display("FAIL slverr_err2: HREADYOUT=%b HRESP=%b HRDATA=%h expected 1 1 12345678", HREADYOUT, HRESP, HRDATA);
    end
    tick();
    n_checks++;
    if ({HREADYOUT, HRESP} !== 2'b10) begin
      n_errors++;
      $display("FAIL slverr_after: HREADYOUT,HRESP=%b expected 10", {HREADYOUT, HRESP});
    end
  endtask

  task automatic test_timeout();
    int lc;
    PRDATA = 32'hA5A55A5A;
    ahb_addr(1'b0, 16'h004C, 32'h0);
    run_apb(100, lc);
    // SETUP + exactly four ACCESS cycles before the forced error
    n_checks++;
    if ({lc == 5, HREADYOUT, HRESP, PSEL, PENABLE} !== 5'b10100) begin
      n_errors++;
      $display("FAIL timeout_err1: cycles=%0d HREADYOUT=%b HRESP=%b PSEL=%b PENABLE=%b expected 5 0 1 0 0",
               lc, HREADYOUT, HRESP, PSEL, PENABLE);
    end
    tick();
    n_checks++;
    if ({HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b1, 32'h12345678}) begin
      n_errors++;
      $display("FAIL timeout_err2: HREADYOUT=%b HRESP=%b HRDATA=%h expected 1 1 12345678", HREADYOUT, HRESP, HRDATA);
    end
    // New read accepted during ERR2, with two wait states: a counter left
    // over from the timeout would expire it early.
    ahb_addr(1'b0, 16'h0050, 32'h0);
    n_checks++;
    if ({HREADYOUT, HRESP, PSEL, PENABLE, PADDR} !== {1'b0, 1'b0, 1'b1, 1'b0, 16'h0050}) begin
      n_errors++;
      $display("FAIL timeout_next_setup: HREADYOUT=%b HRESP=%b PSEL=%b PENABLE=%b PADDR=%h expected 0 0 1 0 0050",
               HREADYOUT, HRESP, PSEL, PENABLE, PADDR);
    end
    run_apb(2, lc);
    n_checks++;
    if ({lc == 4, HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b1, 1'b0, 32'hA5A55A5A}) begin
      n_errors++;
      $display("FAIL timeout_next_read: cycles=%0d HREADYOUT=%b HRESP=%b HRDATA=%h expected 4 1 0 a5a55a5a",
               lc, HREADYOUT, HRESP, HRDATA);
    end
    PREADY = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int lc;
    ahb_addr(1'b1, 16'h0060, 32'h11112222);
    run_apb(0, lc);
    n_checks++;
    if ({lc == 3, HREADYOUT, HRESP} !== 3'b110) begin
      n_errors++;
      $display("FAIL b2b_write_done: cycles=%0d HREADYOUT=%b HRESP=%b expected 3 1 0", lc, HREADYOUT, HRESP);
    end
    // read address phase on the write-completion cycle
    PRDATA = 32'h0BADF00D;
    ahb_addr(1'b0, 16'h0064, 32'h0);
    n_checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b0, 16'h0064, 32'h11112222}) begin
      n_errors++;
      $display("FAIL b2b_read_setup: PSEL=%b PENABLE=%b PWRITE=%b PADDR=%h PWDATA=%h expected 1 0 0 0064 11112222",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    run_apb(0, lc);
    n_checks++;
    if ({lc == 2, HREADYOUT, HRESP, HRDATA} !== {1'b1, 1'b1, 1'b0, 32'h0BADF00D}) begin
      n_errors++;
      $display("FAIL b2b_read_done: cycles=%0d HREADYOUT=%b HRESP=%b HRDATA=%h expected 2 1 0 0badf00d",
               lc, HREADYOUT, HRESP, HRDATA);
    end
    PREADY = 1'b0;
    tick();
  endtask

  task automatic test_no_accept();
    // HTRANS=IDLE, HTRANS=NONSEQ with HREADY low, NONSEQ with HSEL low
    logic [3:0] vec [3];
    vec[0] = 4'b1100;  // {HSEL, HREADY, HTRANS}
    vec[1] = 4'b1010;
    vec[2] = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      HSEL   = vec[i][3];
      HREADY = vec[i][2];
      HTRANS = vec[i][1:0];
      HWRITE = 1'b0;
      HADDR  = 16'h0070;
      tick();
      tick();
      n_checks++;
      if ({PSEL, PENABLE, HREADYOUT, HRESP, dbg_state} !== {4'b0010, 3'd0}) begin
        n_errors++;
        $display("FAIL no_accept_%0d: PSEL=%b PENABLE=%b HREADYOUT=%b HRESP=%b state=%0d expected 0 0 1 0 0",
                 i, PSEL, PENABLE, HREADYOUT, HRESP, dbg_state);
      end
    end
    HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid_access();
    ahb_addr(1'b0, 16'h0080, 32'h0);
    tick();
    n_checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      n_errors++;
      $display("FAIL rst_pre_access: PSEL,PENABLE=%b expected 11", {PSEL, PENABLE});
    end
    #2 HRESETn = 1'b0;
    #1;
    n_checks++;
    if ({HREADYOUT, HRESP, PSEL, PENABLE, PWRITE} !== 5'b10000 || {HRDATA, PADDR, PWDATA} !== '0) begin
      n_errors++;
      $display("FAIL rst_async: HREADYOUT=%b HRESP=%b PSEL=%b PENABLE=%b PWRITE=%b HRDATA=%h PADDR=%h PWDATA=%h expected reset values",
               HREADYOUT, HRESP, PSEL, PENABLE, PWRITE, HRDATA, PADDR, PWDATA);
    end
    tick();
    HRESETn = 1'b1;
    PREADY  = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({HREADYOUT, HRESP, PSEL, HRDATA} !== {3'b100, 32'h0}) begin
      n_errors++;
      $display("FAIL rst_after: HREADYOUT=%b HRESP=%b PSEL=%b HRDATA=%h expected 1 0 0 00000000",
               HREADYOUT, HRESP, PSEL, HRDATA);
    end
    PREADY = 1'b0;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_no_accept();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
